// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI register peripheral.
// Holds the frame layout, the register address map and the FSM state encoding.
package spi_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned DATA_W     = 8;

   // Counter value marking an over-length frame (one bit past a full frame)
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   // Layout of one received frame, MSB first on the wire
   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } frame_t;

endpackage

// File: rtl/spi_sync.sv
// One-bit multi-flop synchronizer into the clk domain.
// Ports: clk, rst (sync, active-high), d (async input), q (synchronized output).
// RST_VAL is the idle level the chain is forced to during reset.
module spi_sync #(
   parameter int unsigned DEPTH   = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stage_q;
   logic [DEPTH-1:0] stage_d;

   // Shift the raw input in at bit 0; bit DEPTH-1 is the settled copy
   always_comb begin
      stage_d = {stage_q[DEPTH-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= {DEPTH{RST_VAL}};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI (mode 0) register peripheral feeding the PWM block.
// Ports: clk, rst (sync, active-high); sclk, copi, ncs (async SPI pins);
// en_reg_out_7_0/en_reg_out_15_8 output enables, en_reg_pwm_7_0/en_reg_pwm_15_8
// PWM mode selects, pwm_duty_cycle shared duty value. All outputs are flops.
// A frame is 16 bits: R/W, 7-bit address, 8-bit data; only exact-length
// writes to a mapped address up to MAX_ADDR update a register.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   localparam int unsigned HOLD_W   = $clog2(SYNC_STAGES + 2);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SYNC_STAGES + 1);

   logic sclk_s, copi_s, ncs_s;

   spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
   );
   spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .d(copi), .q(copi_s)
   );
   spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .d(ncs), .q(ncs_s)
   );

   logic                  sclk_dly_q, sclk_dly_d;
   logic                  ncs_dly_q,  ncs_dly_d;
   logic [HOLD_W-1:0]     hold_q,     hold_d;
   state_e                state_q,    state_d;
   logic [FRAME_BITS-1:0] shift_q,    shift_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;
   logic [7:0]            out_lo_q,   out_lo_d;
   logic [7:0]            out_hi_q,   out_hi_d;
   logic [7:0]            pwm_lo_q,   pwm_lo_d;
   logic [7:0]            pwm_hi_q,   pwm_hi_d;
   logic [7:0]            duty_q,     duty_d;

   logic   sclk_rise, ncs_fall, ncs_rise, hold_done, write_ok;
   frame_t frame;

   // Edge detection on the last synchronizer stage vs. one extra delay flop.
   // After reset the ncs chain drains from its idle 1 towards the pin level;
   // hold_done masks the false falling edge that draining would produce when
   // ncs is already low, so a frame cut by reset stays ignored.
   always_comb begin
      sclk_rise = sclk_s & ~sclk_dly_q;
      ncs_fall  = ~ncs_s & ncs_dly_q & hold_done;
      ncs_rise  = ncs_s & ~ncs_dly_q;
      hold_done = (hold_q == HOLD_MAX);
      frame     = frame_t'(shift_q);
      write_ok  = (cnt_q == CNT_W'(FRAME_BITS)) && frame.wr && (frame.addr <= MAX_ADDR);
   end

   // Next-state, datapath and register-file update
   always_comb begin
      sclk_dly_d = sclk_s;
      ncs_dly_d  = ncs_s;
      hold_d     = hold_q;
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      out_lo_d   = out_lo_q;
      out_hi_d   = out_hi_q;
      pwm_lo_d   = pwm_lo_q;
      pwm_hi_d   = pwm_hi_q;
      duty_d     = duty_q;

      if (!hold_done) begin
         hold_d = hold_q + HOLD_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (ncs_fall) begin
               state_d = ST_SHIFT;
               shift_d = '0;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            // sclk edges coinciding with a deselected ncs are not data
            if (sclk_rise && !ncs_s) begin
               shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
               if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            if (ncs_rise) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            // A new ncs falling edge seen here is dropped on purpose
            state_d = ST_IDLE;
            if (write_ok) begin
               case (frame.addr)
                  ADDR_EN_OUT_LO: out_lo_d = frame.data;
                  ADDR_EN_OUT_HI: out_hi_d = frame.data;
                  ADDR_EN_PWM_LO: pwm_lo_d = frame.data;
                  ADDR_EN_PWM_HI: pwm_hi_d = frame.data;
                  ADDR_DUTY:      duty_d   = frame.data;
                  default: ;
               endcase
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_dly_q <= 1'b0;
         ncs_dly_q  <= 1'b1;
         hold_q     <= '0;
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         out_lo_q   <= 8'h00;
         out_hi_q   <= 8'h00;
         pwm_lo_q   <= 8'h00;
         pwm_hi_q   <= 8'h00;
         duty_q     <= 8'h00;
      end else begin
         sclk_dly_q <= sclk_dly_d;
         ncs_dly_q  <= ncs_dly_d;
         hold_q     <= hold_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         out_lo_q   <= out_lo_d;
         out_hi_q   <= out_hi_d;
         pwm_lo_q   <= pwm_lo_d;
         pwm_hi_q   <= pwm_hi_d;
         duty_q     <= duty_d;
      end
   end

   assign en_reg_out_7_0  = out_lo_q;
   assign en_reg_out_15_8 = out_hi_q;
   assign en_reg_pwm_7_0  = pwm_lo_q;
   assign en_reg_pwm_15_8 = pwm_hi_q;
   assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: the driver queues the hand-computed
// register snapshot for each frame; the monitor pops it on ncs rising and
// compares SYNC_STAGES+3 clk cycles later.
module tb_spi_peripheral;

   localparam int unsigned SYNC    = 2;
   localparam int unsigned CHK_LAT = SYNC + 3;
   localparam int unsigned GAP     = 20;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic sclk = 1'b0;
   logic copi = 1'b0;
   logic ncs  = 1'b1;
   logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;

   int n_tests = 0;
   int n_fail  = 0;

   logic [39:0] exp_q[$];
   string       name_q[$];
   logic [39:0] mon_exp;
   string       mon_name;

   spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
      .clk             (clk),
      .rst             (rst),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (out_lo),
      .en_reg_out_15_8 (out_hi),
      .en_reg_pwm_7_0  (pwm_lo),
      .en_reg_pwm_15_8 (pwm_hi),
      .pwm_duty_cycle  (duty)
   );

   always #5 clk = ~clk;

   // Snapshot order: out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty
   function automatic logic [39:0] snap();
      return {out_lo, out_hi, pwm_lo, pwm_hi, duty};
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Send nbits MSB-first (bit 17 of an over-length frame is 0); optional
   // reset pulse before bit index rst_at; then queue expectation and raise ncs.
   task automatic send_frame(input logic [15:0] w, input int nbits, input int rst_at,
                             input string nm, input logic [39:0] exp);
      logic [16:0] bits;
      bits = {w, 1'b0};
      ncs  = 1'b0;
      wait_clk(4);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            wait_clk(1);
            rst = 1'b0;
         end
         copi = bits[16-i];
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
      wait_clk(4);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      ncs = 1'b1;
   endtask

   // Monitor: compare on each ncs release that has a queued expectation
   initial begin
      forever begin
         @(posedge ncs);
         if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            repeat (CHK_LAT) @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (snap() !== mon_exp) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", mon_name, snap(), mon_exp);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: bench did not finish, %0d pending", exp_q.size());
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      n_tests++;
      if (snap() !== 40'h00_00_00_00_00) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", snap(), 40'h0);
      end

      send_frame(16'h80FF, 16, -1, "wr_out_lo",   40'hFF_00_00_00_00); wait_clk(GAP);
      send_frame(16'h8480, 16, -1, "wr_duty",     40'hFF_00_00_00_80); wait_clk(GAP);
      send_frame(16'h00AA, 16, -1, "read_frame",  40'hFF_00_00_00_80); wait_clk(GAP);
      send_frame(16'h8555, 16, -1, "addr5",       40'hFF_00_00_00_80); wait_clk(GAP);
      send_frame(16'h813C, 15, -1, "short15",     40'hFF_00_00_00_80); wait_clk(GAP);
      send_frame(16'h813C, 17, -1, "long17",      40'hFF_00_00_00_80); wait_clk(GAP);
      send_frame(16'h81A5, 16, -1, "wr_out_hi",   40'hFF_A5_00_00_80); wait_clk(GAP);
      send_frame(16'h82F0, 16, 10, "rst_mid",     40'h00_00_00_00_00); wait_clk(GAP);
      send_frame(16'h82F0, 16, -1, "wr_pwm_lo",   40'h00_00_F0_00_00); wait_clk(GAP);
      send_frame(16'h8301, 16, -1, "b2b_first",   40'h00_00_F0_01_00); wait_clk(2);
      send_frame(16'h8302, 16, -1, "b2b_second",  40'h00_00_F0_02_00); wait_clk(GAP);
      send_frame(16'h8433, 16, -1, "duty_rewr",   40'h00_00_F0_02_33); wait_clk(GAP);

      wait_clk(CHK_LAT + 5);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each input synchronizer (minimum 2).
REQ-002 SHALL have parameter MAX_ADDR, default 7'h04, highest writable register address.
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 SHALL have port copi  input  1  SPI controller-out/peripheral-in data, asynchronous.
REQ-007 SHALL have port ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port en_reg_out_7_0  output  8  output-enable bits for out[7:0].
REQ-009 SHALL have port en_reg_out_15_8  output  8  output-enable bits for out[15:8].
REQ-010 SHALL have port en_reg_pwm_7_0  output  8  PWM-mode select bits for out[7:0].
REQ-011 SHALL have port en_reg_pwm_15_8  output  8  PWM-mode select bits for out[15:8].
REQ-012 SHALL have port pwm_duty_cycle  output  8  shared PWM duty value.

Function
REQ-013 SHALL pass sclk, copi and ncs through SYNC_STAGES-deep synchronizers clocked by clk; all later logic uses only the synchronized copies.
REQ-014 SHALL detect the sclk rising edge, the ncs falling edge and the ncs rising edge by comparing the last synchronizer stage against one extra delay flop.
REQ-015 SHALL implement SPI mode 0: copi is sampled on the synchronized sclk rising edge, MSB first, and sclk edges while ncs is high are ignored.
REQ-016 SHALL frame each transaction as 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-017 SHALL have an FSM with states IDLE, SHIFT and COMMIT.
REQ-018 SHALL move IDLE->SHIFT on the ncs falling edge, clearing the 16-bit shift register and the 5-bit bit counter.
REQ-019 SHALL, in SHIFT, shift in one bit and increment the counter on each sclk rising edge, saturating the counter at 17.
REQ-020 SHALL move SHIFT->COMMIT on the ncs rising edge, and COMMIT->IDLE unconditionally after one clk cycle.
REQ-021 SHALL, in COMMIT, update exactly one register iff counter == 16, R/W == 1 and address <= MAX_ADDR.
REQ-022 SHALL use the address map 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
REQ-023 SHALL make the updated value visible on the output in the clk cycle after COMMIT.
REQ-024 SHALL make the write visible no later than SYNC_STAGES+3 clk cycles after the ncs pin rises.
REQ-025 SHALL discard, with all registers unchanged: frames of fewer than 16 bits, frames of more than 16 bits (counter == 17), frames with R/W == 0, and frames with address > MAX_ADDR.
REQ-026 SHALL, if an ncs falling edge arrives in COMMIT, complete the commit and then return to IDLE; that frame is lost, and the next frame starts at the next ncs falling edge.
REQ-027 SHALL keep each register at its last written value until overwritten or reset, with writes to the same address taking last-writer-wins order.
REQ-028 SHALL provide no read-back and no MISO output.

Reset
REQ-029 SHALL, when rst is high at a clk rising edge, set all five registers to 8'h00, all synchronizer flops to their idle levels (sclk 0, copi 0, ncs 1), the FSM to IDLE, and the counter and shift register to 0.
REQ-030 SHALL, on a reset asserted mid-frame, abort the frame with no register update; bits clocked after rst deasserts are ignored until the next ncs falling edge.

Structure
REQ-031 SHALL place the address constants (ADDR_EN_OUT_LO ... ADDR_DUTY), FRAME_BITS = 16 and the FSM state enum in shared package spi_pkg.
REQ-032 SHALL implement the synchronizer as sub-module spi_sync (parameterized depth, one bit wide, three instances).
REQ-033 SHALL keep the register file in spi_peripheral and connect its outputs directly to pwm_peripheral.

Verification
REQ-034 SHALL cover: reset, then write 0x80_FF (addr 0x00, data 0xFF) -> en_reg_out_7_0 == 0xFF, other registers 0x00.
REQ-035 SHALL cover: write 0x84_80 -> pwm_duty_cycle == 0x80 within SYNC_STAGES+3 cycles of ncs rising.
REQ-036 SHALL cover: read frame 0x00_AA, then write 0x85_55 (addr 5) -> all registers unchanged.
REQ-037 SHALL cover: a 15-bit frame and a 17-bit frame, each carrying addr 0x01, data 0x3C -> en_reg_out_15_8 stays 0x00.
REQ-038 SHALL cover: rst pulsed after 10 bits of 0x82_F0 -> no update; the following full 0x82_F0 -> en_reg_pwm_7_0 == 0xF0.
REQ-039 SHALL cover: back-to-back writes 0x83_01 then 0x83_02 with 2 clk of ncs high between them -> final en_reg_pwm_15_8 == 0x02.
